// File: rtl/note_tone_decoder.sv
`default_nettype none
// ============================================================================
// Module   : note_tone_decoder
// Brief    : Debounces a 3-bit note code from the datapath link, decodes it to
//            a one-hot note and drives a square-wave buzzer with a minimum hold.
// Revision : 1.0 - initial release
// ============================================================================
module note_tone_decoder #(
  parameter int STABLE_CYCLES   = 4,
  parameter int MIN_HOLD_CYCLES = 50000,
  parameter int SIM_SHIFT       = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] code_in,
  input  logic       enable,
  output logic       buzzer,
  output logic       note_active,
  output logic [6:0] note_onehot,
  output logic       note_changed,
  output logic [1:0] db_state
);

  localparam logic [1:0]  ST_IDLE  = 2'b00;
  localparam logic [1:0]  ST_PLAY  = 2'b01;
  localparam logic [1:0]  ST_HOLD  = 2'b10;
  localparam logic [3:0]  STABLE   = 4'(STABLE_CYCLES);
  localparam logic [19:0] MIN_HOLD = 20'(MIN_HOLD_CYCLES);

  logic [2:0]  s1_q, s1_d, s2_q, s2_d;
  logic [2:0]  cand_q, cand_d, acc_q, acc_d;
  logic [3:0]  stab_q, stab_d;
  logic [1:0]  state_q, state_d;
  logic [2:0]  note_q, note_d;
  logic [6:0]  onehot_q, onehot_d;
  logic [16:0] half_cnt_q, half_cnt_d;
  logic        phase_q, phase_d;
  logic [19:0] hold_q, hold_d;
  logic        changed_q, changed_d;
  logic        buzzer_q, buzzer_d;

  logic [16:0] half_raw, half_len;
  logic        onset, release_ev, hold_full;

  // Plain two-flop synchronizer followed by the stability filter.
  always_comb begin
    s1_d   = code_in;
    s2_d   = s1_q;
    cand_d = cand_q;
    stab_d = stab_q;
    acc_d  = acc_q;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      stab_d = 4'd1;
    end else begin
      if (stab_q == STABLE && cand_q != acc_q) acc_d = cand_q;
      if (stab_q != STABLE) stab_d = stab_q + 4'd1;
    end
  end

  assign onset      = (acc_d != acc_q) && (acc_d != 3'd0);
  assign release_ev = (acc_d != acc_q) && (acc_d == 3'd0);
  assign hold_full  = (hold_q == MIN_HOLD);

  always_comb begin
    case (note_q)
      3'd1:    half_raw = 17'd95556;
      3'd2:    half_raw = 17'd85131;
      3'd3:    half_raw = 17'd75843;
      3'd4:    half_raw = 17'd71586;
      3'd5:    half_raw = 17'd63776;
      3'd6:    half_raw = 17'd56818;
      3'd7:    half_raw = 17'd50619;
      default: half_raw = 17'd1;
    endcase
    half_len = half_raw >> SIM_SHIFT;
    if (half_len == 17'd0) half_len = 17'd1;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; an onset always wins over a hold expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (onset) state_d = ST_PLAY;
      ST_PLAY: begin
        if (onset)           state_d = ST_PLAY;
        else if (release_ev) state_d = hold_full ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        if (onset)          state_d = ST_PLAY;
        else if (hold_full) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / tone datapath
  always_comb begin
    changed_d  = onset;
    hold_d     = onset ? 20'd0 : (hold_full ? hold_q : hold_q + 20'd1);
    note_d     = note_q;
    onehot_d   = onehot_q;
    half_cnt_d = half_cnt_q;
    phase_d    = phase_q;
    if (onset) begin
      note_d     = acc_d;
      onehot_d   = 7'd1 << (acc_d - 3'd1);
      half_cnt_d = 17'd0;
      phase_d    = 1'b1;
    end else if (state_d == ST_IDLE) begin
      note_d     = 3'd0;
      onehot_d   = 7'd0;
      half_cnt_d = 17'd0;
      phase_d    = 1'b0;
    end else if (half_cnt_q == half_len - 17'd1) begin
      half_cnt_d = 17'd0;
      phase_d    = ~phase_q;
    end else begin
      half_cnt_d = half_cnt_q + 17'd1;
    end
    buzzer_d = phase_d & enable & (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q       <= 3'd0;
      s2_q       <= 3'd0;
      cand_q     <= 3'd0;
      acc_q      <= 3'd0;
      stab_q     <= 4'd0;
      note_q     <= 3'd0;
      onehot_q   <= 7'd0;
      half_cnt_q <= 17'd0;
      phase_q    <= 1'b0;
      hold_q     <= 20'd0;
      changed_q  <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      cand_q     <= cand_d;
      acc_q      <= acc_d;
      stab_q     <= stab_d;
      note_q     <= note_d;
      onehot_q   <= onehot_d;
      half_cnt_q <= half_cnt_d;
      phase_q    <= phase_d;
      hold_q     <= hold_d;
      changed_q  <= changed_d;
      buzzer_q   <= buzzer_d;
    end
  end

  always_comb begin
    buzzer       = buzzer_q;
    note_active  = (state_q != ST_IDLE);
    note_onehot  = onehot_q;
    note_changed = changed_q;
    db_state     = state_q;
  end

endmodule
`default_nettype wire

// File: doc/note_tone_decoder.md
Name: note_tone_decoder

Overview:
- Receiving end of the 3-bit note link driven by the game datapath's Arduino output.
- Takes the encoded note code, removes glitches from it, and decodes it to a one-hot note.
- Drives a square-wave buzzer at the pitch of that note, and holds each note for a minimum audible time.
- Sits on the sound board side of the link and replaces the Arduino tone generator with on-FPGA logic.

Parameters:
- STABLE_CYCLES, 4: number of consecutive identical synchronized samples needed before a code is accepted (range 1..15).
- MIN_HOLD_CYCLES, 50000: minimum number of cycles a note sounds after its onset (range 1..2^20-1).
- SIM_SHIFT, 0: right shift applied to every half-period table entry. Used to shorten periods in simulation.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- code_in  in  3  note code, asynchronous to clock. 0 = silence; k = 1..7 = note k (button bit k-1).
- enable  in  1  1 = buzzer may toggle. 0 = mute only; state, counters and flags keep running.
- buzzer  out  1  square-wave tone output.
- note_active  out  1  1 while state is PLAY or HOLD.
- note_onehot  out  7  one-hot copy of the note currently sounding; 0 in IDLE.
- note_changed  out  1  one-cycle pulse on every note onset, including a note-to-note change.
- db_state  out  2  debug: 00 IDLE, 01 PLAY, 10 HOLD.

Behaviour:
- Reset: clock and reset are as already decided (reset reset, synchronous, active-high; clock clock). On reset:
  - buzzer=0, note_active=0, note_onehot=0, note_changed=0, state=IDLE.
  - synchronizer stages=0, candidate=0, accepted=0.
  - all counters=0, phase=0.
  - Reset mid-note silences the buzzer on the next edge.
- Synchronizer: two flops on code_in (s1, s2). No logic between the two stages.
- Glitch filter:
  - If s2 != candidate: candidate<=s2, stab_cnt<=1.
  - Else: stab_cnt increments, saturating at STABLE_CYCLES.
  - accepted<=candidate on an edge where stab_cnt==STABLE_CYCLES, s2==candidate and candidate!=accepted.
  - Latency from the first edge that samples the new code_in to accepted updating: STABLE_CYCLES+3 edges (7 at default).
  - A code present for fewer than STABLE_CYCLES+1 samples is never accepted.
- Half-period table, in cycles, before SIM_SHIFT:
  - code 1: 95556 (C4)
  - code 2: 85131 (D4)
  - code 3: 75843 (E4)
  - code 4: 71586 (F4)
  - code 5: 63776 (G4)
  - code 6: 56818 (A4)
  - code 7: 50619 (B4)
  - HALF = entry >> SIM_SHIFT, held in 17 bits. If HALF evaluates to 0 it is forced to 1.
- Onset event: the edge where accepted changes to a nonzero value different from the note that is sounding. On that edge:
  - half_cnt<=0, phase<=1, hold_cnt<=0.
  - note_onehot<=1<<(code-1).
  - note_changed=1 for exactly that cycle.
- Tone generation:
  - In PLAY or HOLD, half_cnt counts 0..HALF-1. At HALF-1 it wraps to 0 and phase toggles.
  - buzzer = phase & enable & note_active, registered.
  - Output period is 2*HALF cycles at 50% duty.
- hold_cnt: increments every cycle from onset and saturates at MIN_HOLD_CYCLES.
- State machine:
  - IDLE -> PLAY on an onset event.
  - PLAY -> PLAY on an onset with a different code; the tone restarts.
  - PLAY -> IDLE when accepted becomes 0 and hold_cnt==MIN_HOLD_CYCLES.
  - PLAY -> HOLD when accepted becomes 0 and hold_cnt<MIN_HOLD_CYCLES. In HOLD the last note keeps sounding.
  - HOLD -> IDLE when hold_cnt reaches MIN_HOLD_CYCLES.
  - HOLD -> PLAY on an onset event during HOLD. The new note wins and hold_cnt restarts.
  - Entering IDLE clears note_onehot, phase and half_cnt.
- Simultaneous events: reset has priority over everything, and an onset has priority over the HOLD->IDLE exit in the same cycle.
- Repeated code: the same nonzero code re-accepted after passing through 0 is a new onset (new note_changed pulse).

Test Plan:
- Reset check, SIM_SHIFT=8, MIN_HOLD=100: assert reset for 3 cycles with code_in=6 -> all outputs 0, db_state=00. Release reset -> note_changed pulses on edge 7 after release, note_onehot=0100000, buzzer period 442 cycles, 221 high.
- Glitch rejection: code_in=3 for 3 cycles, then back to 0 -> accepted stays 0, no note_changed, buzzer stays 0. Holding code 3 for 20 cycles -> onset, note_onehot=0000100, HALF=296.
- Minimum hold: code 1 for 20 cycles, then 0 -> db_state=10 until hold_cnt reaches 100 after onset, then IDLE. buzzer keeps its 373-cycle half period until then.
- Note change: 2 then 7 back to back -> second note_changed pulse, phase restarts high, half_cnt=0, note_onehot=1000000, HALF=197.
- Mute: enable=0 during PLAY with code 5 -> buzzer=0, note_active=1, half_cnt keeps counting. Re-enable -> buzzer resumes in the correct phase.
- Reset mid-note and HOLD interrupt: reset during HOLD -> IDLE on the next edge. Separately, code 4 arriving during HOLD -> PLAY with HALF=279.
